mips_seq_divider: RTL and testbench



---
 rtl/mips_div_pkg.sv | 14 +
 rtl/mips_seq_divider_div_step.sv | 23 ++
 rtl/mips_seq_divider.sv | 104 ++++++++++
 tb/tb_mips_seq_divider.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the sequential MIPS DIV/DIVU unit.
package mips_div_pkg;

   localparam int unsigned WIDTH_DEFAULT = 32;
   localparam int unsigned CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/mips_seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Remainder stays below dvs, so the shifted value always fits in WIDTH+1 bits.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, dvs};
      quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
      rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

endmodule

// File: rtl/mips_seq_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, results held for LO/HI.
module mips_seq_divider
   import mips_div_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   div_state_t       state, state_nxt;
   logic             accept;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [WIDTH-1:0] dividend_abs, divisor_abs;
   logic             qneg, rneg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dvs      (dvs_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; a start is only honoured while no division is in flight.
   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (start) begin
               accept    = 1'b1;
               state_nxt = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN:     if (cnt == CNT_W'(1)) state_nxt = SIGN;
         SIGN:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand, iteration and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         qneg        <= 1'b0;
         rneg        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy <= (state_nxt == RUN) || (state_nxt == SIGN);
         done <= (state_nxt == DONE);
         if (accept) begin
            rem_q <= '0;
            quo_q <= dividend_abs;
            dvs_q <= divisor_abs;
            cnt   <= CNT_W'(WIDTH);
            qneg  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg  <= is_signed && dividend[WIDTH-1];
            if (divisor == '0) begin
               quotient    <= '1;
               remainder   <= dividend;
               div_by_zero <= 1'b1;
            end
         end else if (state == RUN) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt - CNT_W'(1);
         end else if (state == SIGN) begin
            quotient    <= qneg ? -quo_q : quo_q;
            remainder   <= rneg ? -rem_q : rem_q;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mips_seq_divider.sv
// Self-checking bench for mips_seq_divider against an arithmetic reference model.
module tb_mips_seq_divider;

   localparam int unsigned W = 32;
   localparam int NORM_LAT = 33;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int nvec = 0;
   int nerr = 0;

   mips_seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: MIPS DIV/DIVU semantics via 64-bit integer arithmetic (truncating division).
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                   output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
      longint sa, sb;
      if (b == 0) begin
         q = '1; r = a; dz = 1'b1;
      end else if (s) begin
         sa = {{32{a[W-1]}}, a};
         sb = {{32{b[W-1]}}, b};
         q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
      end else begin
         q = a / b; r = a % b; dz = 1'b0;
      end
   endfunction

   // Present operands with start for one edge; returns just after the sampling edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
      dividend = a; divisor = b; is_signed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Edges after the start edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 0; n <= 200; n++) begin
         if (done) begin lat = n; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      nvec++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got b=%b d=%b z=%b q=%h r=%h want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      nvec++;
      if ({busy, done} !== 2'b00) begin
         nerr++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_unsigned_basic();
      int lat;
      launch(32'd100, 32'd7, 1'b0);
      nvec++;
      if (busy !== 1'b1) begin nerr++; $display("FAIL u100_busy: got %b want 1", busy); end
      wait_done(lat);
      nvec++;
      if (lat != NORM_LAT) begin nerr++; $display("FAIL u100_latency: got %0d want %0d", lat, NORM_LAT); end
      nvec++;
      if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
         nerr++; $display("FAIL u100_result: got q=%h r=%h z=%b want q=e r=2 z=0", quotient, remainder, div_by_zero);
      end
      nvec++;
      if (busy !== 1'b0) begin nerr++; $display("FAIL u100_busy_at_done: got %b want 0", busy); end
      repeat (3) @(posedge clk); #1;
      nvec++;
      if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
         nerr++; $display("FAIL u100_hold: got d=%b q=%h r=%h want d=0 q=e r=2", done, quotient, remainder);
      end
   endtask

   task automatic test_signed_table();
      logic [W-1:0] ta [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
      logic [W-1:0] tb [3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      logic [W-1:0] tq [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD};
      logic [W-1:0] tr [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      int lat;
      for (int i = 0; i < 3; i++) begin
         launch(ta[i], tb[i], 1'b1);
         wait_done(lat);
         nvec++;
         if (lat != NORM_LAT || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
            nerr++;
            $display("FAIL signed_%0d: got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=0",
                     i, lat, quotient, remainder, div_by_zero, NORM_LAT, tq[i], tr[i]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      int lat;
      launch(32'h1234_5678, 32'h0, 1'b0);
      nvec++;
      if (busy !== 1'b0) begin nerr++; $display("FAIL dz_busy: got %b want 0", busy); end
      wait_done(lat);
      nvec++;
      if (lat != 0) begin nerr++; $display("FAIL dz_latency: got %0d want 0", lat); end
      nvec++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
         nerr++; $display("FAIL dz_result: got q=%h r=%h z=%b want q=ffffffff r=12345678 z=1",
                          quotient, remainder, div_by_zero);
      end
      @(posedge clk); #1;
      nvec++;
      if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
         nerr++; $display("FAIL dz_after: got d=%b b=%b z=%b want 0 0 1", done, busy, div_by_zero);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      launch(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_done(lat);
      nvec++;
      if (lat != NORM_LAT || quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
         nerr++; $display("FAIL b2b_first: got lat=%0d q=%h r=%h want lat=%0d q=ffffffff r=0",
                          lat, quotient, remainder, NORM_LAT);
      end
      launch(32'd10, 32'd3, 1'b0);
      nvec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         nerr++; $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy, done);
      end
      nvec++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
         nerr++; $display("FAIL b2b_hold: got q=%h r=%h want ffffffff 0", quotient, remainder);
      end
      wait_done(lat);
      nvec++;
      if (lat != NORM_LAT || quotient !== 32'd3 || remainder !== 32'd1) begin
         nerr++; $display("FAIL b2b_second: got lat=%0d q=%h r=%h want lat=%0d q=3 r=1",
                          lat, quotient, remainder, NORM_LAT);
      end
   endtask

   task automatic test_ignore_and_abort();
      int lat;
      logic [W-1:0] eq, er;
      bit ez;
      launch(32'd1000, 32'd9, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      dividend = 32'd5; divisor = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
      nvec++;
      if (lat + 5 != NORM_LAT || quotient !== 32'd111 || remainder !== 32'd1 || div_by_zero !== 1'b0) begin
         nerr++; $display("FAIL ignore_start: got lat=%0d q=%h r=%h z=%b want lat=%0d q=6f r=1 z=0",
                          lat + 5, quotient, remainder, div_by_zero, NORM_LAT);
      end
      launch(32'hDEAD_BEEF, 32'd77, 1'b0);
      repeat (19) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         nerr++; $display("FAIL abort_reset: got b=%b d=%b z=%b q=%h r=%h want all 0",
                          busy, done, div_by_zero, quotient, remainder);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      ref_div(32'hDEAD_BEEF, 32'd77, 1'b0, eq, er, ez);
      launch(32'hDEAD_BEEF, 32'd77, 1'b0);
      wait_done(lat);
      nvec++;
      if (lat != NORM_LAT || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
         nerr++; $display("FAIL after_abort: got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
                          lat, quotient, remainder, div_by_zero, NORM_LAT, eq, er, ez);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, eq, er;
      bit s, ez;
      int lat, mode;
      for (int i = 0; i < 40; i++) begin
         mode = int'($urandom_range(0, 5));
         a = $urandom; b = $urandom; s = 1'($urandom);
         case (mode)
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1; end
            3: a = W'($urandom_range(0, 1000));
            default: ;
         endcase
         ref_div(a, b, s, eq, er, ez);
         launch(a, b, s);
         nvec++;
         if (busy !== !ez) begin
            nerr++; $display("FAIL rand_%0d_busy: got %b want %b", i, busy, !ez);
         end
         wait_done(lat);
         nvec++;
         if (lat != (ez ? 0 : NORM_LAT)) begin
            nerr++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, ez ? 0 : NORM_LAT);
         end
         nvec++;
         if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            nerr++; $display("FAIL rand_%0d_result a=%h b=%h s=%b: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                             i, a, b, s, quotient, remainder, div_by_zero, eq, er, ez);
         end
         if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed_table();
      test_div_by_zero();
      test_back_to_back();
      test_ignore_and_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
